ripple_carry_adder: RTL and testbench

//   Registered N-bit unsigned ripple-carry adder: sum/cout = a + b + cin.

---
 rtl/ripple_carry_adder_pkg.sv | 10 +
 rtl/ripple_carry_adder_if.sv | 43 ++++
 rtl/full_adder.sv | 22 ++
 rtl/ripple_carry_adder.sv | 63 ++++++
 tb/tb_ripple_carry_adder.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/ripple_carry_adder_pkg.sv
// ripple_carry_adder_pkg
//   Shared constants for the registered ripple-carry adder slice.
//   DEFAULT_WIDTH : operand/sum width used when a parent does not override it.
//   MAX_WIDTH     : widest operand the adder is intended for.
package ripple_carry_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned MAX_WIDTH     = 64;

endpackage

// File: rtl/ripple_carry_adder_if.sv
// ripple_carry_adder_if
//   Operand/result bundle for ripple_carry_adder.
//   in_valid, a, b, cin : operands, driven by the requester (master).
//   sum, cout, ovf      : registered result, driven by the adder (slave).
//   out_valid           : one-cycle pulse marking a freshly captured result.
interface ripple_carry_adder_if
    import ripple_carry_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             out_valid;

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        input  sum,
        input  cout,
        input  ovf,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        output sum,
        output cout,
        output ovf,
        output out_valid
    );

endinterface

// File: rtl/full_adder.sv
// full_adder
//   Purely combinational 1-bit full adder, one stage of the ripple chain.
//   a, b : operand bits
//   ci   : carry in from the next-lower bit
//   s    : sum bit
//   co   : carry out to the next-higher bit
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term, shared by sum and carry.
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder
//   Registered WIDTH-bit unsigned adder: {cout,sum} = a + b + cin, built from a
//   chain of full_adder stages (no lookahead). The result is captured one clock
//   after a valid input; there is no backpressure.
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset, takes priority over in_valid
//   bus  : slave side of ripple_carry_adder_if (operands in, registered result out)
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input logic                 clk,
    input logic                 rst,
    ripple_carry_adder_if.slave bus
);

    // Carry vector: c[0] is the carry in, c[WIDTH] the carry out.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             out_valid_q;

    assign c[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a  (bus.a[i]),
            .b  (bus.b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    // Operands are only looked at when in_valid is high, so junk on a/b/cin
    // in idle cycles never reaches the result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (bus.in_valid) begin
            sum_q       <= s;
            cout_q      <= c[WIDTH];
            // Signed overflow: carry into the sign bit differs from carry out.
            ovf_q       <= c[WIDTH] ^ c[WIDTH-1];
            out_valid_q <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb_ripple_carry_adder
//   Directed and randomized self-checking bench for ripple_carry_adder, WIDTH=4.
//   Inputs change on the falling edge; outputs are sampled 1 ns after the
//   rising edge that captures them.
module tb_ripple_carry_adder;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    ripple_carry_adder_if #(.WIDTH(W)) bus ();

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin);
        @(negedge clk);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string name, input int idx, input vec_t v);
        total++;
        if (bus.sum !== v.sum) begin
            bad++;
            $display("FAIL %s[%0d] sum: got %b want %b", name, idx, bus.sum, v.sum);
        end
        total++;
        if (bus.cout !== v.cout) begin
            bad++;
            $display("FAIL %s[%0d] cout: got %b want %b", name, idx, bus.cout, v.cout);
        end
        total++;
        if (bus.ovf !== v.ovf) begin
            bad++;
            $display("FAIL %s[%0d] ovf: got %b want %b", name, idx, bus.ovf, v.ovf);
        end
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s[%0d] out_valid: got %b want 1", name, idx, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.cin      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.sum, bus.cout, bus.ovf, bus.out_valid} !== 7'b0) begin
            bad++;
            $display("FAIL reset_state: got sum=%b cout=%b ovf=%b ov=%b want all 0",
                     bus.sum, bus.cout, bus.ovf, bus.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        total++;
        if ({bus.sum, bus.cout, bus.ovf, bus.out_valid} !== 7'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got sum=%b cout=%b ovf=%b ov=%b want all 0",
                     bus.sum, bus.cout, bus.ovf, bus.out_valid);
        end
    endtask

    task automatic test_basic();
        vec_t v[4];
        //          a        b        cin   sum      cout  ovf
        v[0] = '{4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0};
        v[1] = '{4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0, 1'b0};
        v[2] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
        v[3] = '{4'b1001, 4'b0110, 1'b1, 4'b0000, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, v[i].a, v[i].b, v[i].cin);
            check_vec("basic", i, v[i]);
            drive(1'b0, '0, '0, 1'b0);
        end
    endtask

    task automatic test_overflow();
        vec_t v[2];
        v[0] = '{4'b0111, 4'b0111, 1'b0, 4'b1110, 1'b0, 1'b1};
        v[1] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, v[i].a, v[i].b, v[i].cin);
            check_vec("overflow", i, v[i]);
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[5];
        v[0] = '{4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b0};
        v[1] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
        v[2] = '{4'b1000, 4'b0111, 1'b1, 4'b0000, 1'b1, 1'b0};
        v[3] = '{4'b1100, 4'b0110, 1'b0, 4'b0010, 1'b1, 1'b0};
        v[4] = '{4'b0110, 4'b0011, 1'b0, 4'b1001, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, v[i].a, v[i].b, v[i].cin);
            check_vec("stream", i, v[i]);
        end
        // Idle with undriven operands: result must hold, valid must drop.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 4'bxxxx, 4'bxxxx, 1'bx);
            total++;
            if ({bus.sum, bus.cout, bus.ovf} !== 6'b1001_0_1) begin
                bad++;
                $display("FAIL hold[%0d]: got sum=%b cout=%b ovf=%b want 1001 0 1",
                         i, bus.sum, bus.cout, bus.ovf);
            end
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL hold_valid[%0d]: got %b want 0", i, bus.out_valid);
            end
        end
    endtask

    task automatic test_reset_priority();
        vec_t v;
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 4'b1111, 4'b1111, 1'b1);
        total++;
        if ({bus.sum, bus.cout, bus.ovf, bus.out_valid} !== 7'b0) begin
            bad++;
            $display("FAIL rst_priority: got sum=%b cout=%b ovf=%b ov=%b want all 0",
                     bus.sum, bus.cout, bus.ovf, bus.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        v = '{4'b0101, 4'b0100, 1'b1, 4'b1010, 1'b0, 1'b1};
        drive(1'b1, v.a, v.b, v.cin);
        check_vec("after_rst", 0, v);
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W:0]   exp;
        logic         exp_ovf;
        for (int i = 0; i < 1000; i++) begin
            a   = W'($urandom_range(0, 15));
            b   = W'($urandom_range(0, 15));
            cin = 1'($urandom_range(0, 1));
            exp = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
            // Signed overflow: operands share a sign that the result does not.
            exp_ovf = (a[W-1] == b[W-1]) && (exp[W-1] != a[W-1]);
            drive(1'b1, a, b, cin);
            total++;
            if ({bus.cout, bus.sum} !== exp || bus.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL random[%0d] %b+%b+%b: got {cout,sum}=%b ov=%b want %b ov=1",
                         i, a, b, cin, {bus.cout, bus.sum}, bus.out_valid, exp);
            end
            total++;
            if (bus.ovf !== exp_ovf) begin
                bad++;
                $display("FAIL random_ovf[%0d] %b+%b+%b: got %b want %b",
                         i, a, b, cin, bus.ovf, exp_ovf);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_reset_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
